// File: rtl/mcycle_control.sv
// Multi-cycle CPU control unit: Moore FSM over IF/ID/EX/MEM/WB/HALT driving
// datapath enables, plus a retired-instruction counter.
module mcycle_control #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic                 bcond,
  input  logic                 mem_ready,
  output logic [2:0]           state,
  output logic                 alu_mode,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 reg_write,
  output logic                 output_valid,
  output logic                 is_halted,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic [1:0]           pc_src,
  output logic [WORD_SIZE-1:0] num_inst
);

  localparam logic [3:0] OPCODE_BNE = 4'd0;
  localparam logic [3:0] OPCODE_BLZ = 4'd3;
  localparam logic [3:0] OPCODE_ADI = 4'd4;
  localparam logic [3:0] OPCODE_ORI = 4'd5;
  localparam logic [3:0] OPCODE_LHI = 4'd6;
  localparam logic [3:0] OPCODE_LWD = 4'd7;
  localparam logic [3:0] OPCODE_SWD = 4'd8;
  localparam logic [3:0] OPCODE_JMP = 4'd9;
  localparam logic [3:0] OPCODE_JAL = 4'd10;
  localparam logic [3:0] OPCODE_R   = 4'd15;

  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] num_inst_q;
  logic                 ir_write_c, pc_write_c;
  logic                 retire;

  logic is_r, is_jpr, is_jrl, is_wwd, is_hlt;
  logic is_lwd, is_swd, is_branch, is_imm, is_jmp, is_jal;

  // The branch decision itself is qualified by bcond in the datapath.
  logic unused_bcond;
  assign unused_bcond = bcond;

  assign is_r      = (opcode == OPCODE_R);
  assign is_jpr    = is_r && (func_code == FUNC_JPR);
  assign is_jrl    = is_r && (func_code == FUNC_JRL);
  assign is_wwd    = is_r && (func_code == FUNC_WWD);
  assign is_hlt    = is_r && (func_code == FUNC_HLT);
  assign is_lwd    = (opcode == OPCODE_LWD);
  assign is_swd    = (opcode == OPCODE_SWD);
  assign is_branch = (opcode >= OPCODE_BNE) && (opcode <= OPCODE_BLZ);
  assign is_imm    = (opcode == OPCODE_ADI) || (opcode == OPCODE_ORI) ||
                     (opcode == OPCODE_LHI);
  assign is_jmp    = (opcode == OPCODE_JMP);
  assign is_jal    = (opcode == OPCODE_JAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      num_inst_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        num_inst_q <= num_inst_q + WORD_SIZE'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_mode      = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    output_valid  = 1'b0;
    is_halted     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    pc_src        = 2'd0;
    unique case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_ID;
        end
      end
      S_ID: begin
        if (is_hlt) begin
          state_d = S_HALT;
        end else if (is_jmp || is_jal) begin
          pc_write_c = 1'b1;
          pc_src     = 2'd2;
          state_d    = is_jal ? S_WB : S_IF;
        end else if (is_jpr || is_jrl) begin
          pc_write_c = 1'b1;
          pc_src     = 2'd3;
          state_d    = is_jrl ? S_WB : S_IF;
        end else if (is_wwd) begin
          output_valid = 1'b1;
          state_d      = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_mode = !(is_lwd || is_swd);
        if (is_lwd || is_swd) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_write_cond = 1'b1;
          pc_src        = 2'd1;
          state_d       = S_IF;
        end else if (is_r || is_imm) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_lwd;
        mem_write = is_swd;
        if (mem_ready) begin
          state_d = is_lwd ? S_WB : S_IF;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // An instruction retires when it leaves for IF or HALT; the HALT self-loop is not a retirement.
  assign retire = (state_q != S_IF) && (state_d != state_q) &&
                  ((state_d == S_IF) || (state_d == S_HALT));

  assign ir_write = ir_write_c && !reset;
  assign pc_write = pc_write_c && !reset;
  assign state    = state_q;
  assign num_inst = num_inst_q;

endmodule

// File: tb/tb_mcycle_control.sv
// Self-checking bench for mcycle_control: per-instruction expected cycle traces
// derived from instruction class, plus a counter model.
module tb_mcycle_control;

  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
  localparam int C_ALU = 0, C_IMM = 1, C_LWD = 2, C_SWD = 3, C_BR = 4, C_JMP = 5,
                 C_JPR = 6, C_WWD = 7, C_JAL = 8, C_JRL = 9, C_HLT = 10, C_UNDEF = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic [5:0]  func_code = 6'd0;
  logic        bcond = 1'b0;
  logic        mem_ready = 1'b0;

  logic [2:0]  state, state_s;
  logic        alu_mode, ir_write, pc_write, pc_write_cond, reg_write, output_valid, is_halted;
  logic        mem_read, mem_write, i_or_d;
  logic        alu_mode_s, ir_write_s, pc_write_s, pc_write_cond_s, reg_write_s, output_valid_s;
  logic        is_halted_s, mem_read_s, mem_write_s, i_or_d_s;
  logic [1:0]  pc_src, pc_src_s;
  logic [15:0] num_inst;
  logic [3:0]  num_inst_s;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned model_cnt = 0;
  logic [14:0] obs_q[$];
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  mcycle_control #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code), .bcond(bcond),
    .mem_ready(mem_ready), .state(state), .alu_mode(alu_mode), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .output_valid(output_valid), .is_halted(is_halted), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .pc_src(pc_src), .num_inst(num_inst)
  );

  mcycle_control #(.WORD_SIZE(4)) dut_s (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code), .bcond(bcond),
    .mem_ready(mem_ready), .state(state_s), .alu_mode(alu_mode_s), .ir_write(ir_write_s),
    .pc_write(pc_write_s), .pc_write_cond(pc_write_cond_s), .reg_write(reg_write_s),
    .output_valid(output_valid_s), .is_halted(is_halted_s), .mem_read(mem_read_s),
    .mem_write(mem_write_s), .i_or_d(i_or_d_s), .pc_src(pc_src_s), .num_inst(num_inst_s)
  );

  function automatic int classify(input logic [3:0] op, input logic [5:0] fn);
    if (op == 4'd15) begin
      case (fn)
        6'd25:   return C_JPR;
        6'd26:   return C_JRL;
        6'd28:   return C_WWD;
        6'd29:   return C_HLT;
        default: return C_ALU;
      endcase
    end
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: return C_BR;
      4'd4, 4'd5, 4'd6:       return C_IMM;
      4'd7:                   return C_LWD;
      4'd8:                   return C_SWD;
      4'd9:                   return C_JMP;
      4'd10:                  return C_JAL;
      default:                return C_UNDEF;
    endcase
  endfunction

  // {state, alu_mode, ir_write, pc_write, pc_write_cond, reg_write, output_valid,
  //  is_halted, mem_read, mem_write, i_or_d, pc_src}
  function automatic logic [14:0] expect_out(input int ph, input int cls, input logic mr);
    logic am, irw, pcw, pwc, rw, ov, hl, mrd, mwr, iod;
    logic [1:0] ps;
    {am, irw, pcw, pwc, rw, ov, hl, mrd, mwr, iod} = '0;
    ps = 2'd0;
    case (ph)
      P_IF:  begin mrd = 1'b1; irw = mr; pcw = mr; end
      P_ID: begin
        if (cls == C_JMP || cls == C_JAL) begin pcw = 1'b1; ps = 2'd2; end
        if (cls == C_JPR || cls == C_JRL) begin pcw = 1'b1; ps = 2'd3; end
        if (cls == C_WWD) ov = 1'b1;
      end
      P_EX: begin
        am = !(cls == C_LWD || cls == C_SWD);
        if (cls == C_BR) begin pwc = 1'b1; ps = 2'd1; end
      end
      P_MEM: begin iod = 1'b1; mrd = (cls == C_LWD); mwr = (cls == C_SWD); end
      P_WB:  rw = 1'b1;
      P_HALT: hl = 1'b1;
      default: ;
    endcase
    return {3'(ph), am, irw, pcw, pwc, rw, ov, hl, mrd, mwr, iod, ps};
  endfunction

  function automatic logic [14:0] actual();
    return {state, alu_mode, ir_write, pc_write, pc_write_cond, reg_write, output_valid,
            is_halted, mem_read, mem_write, i_or_d, pc_src};
  endfunction

  // Entered at a falling edge; samples one cycle and advances to the next falling edge.
  task automatic cycle(input int ph, input int cls, input logic mr);
    mem_ready = mr;
    bcond = 1'($urandom);
    #1;
    obs_q.push_back(actual());
    exp_q.push_back(expect_out(ph, cls, mr));
    @(negedge clk);
  endtask

  task automatic exec_instr(input logic [3:0] op, input logic [5:0] fn,
                            input int unsigned if_wait, input int unsigned mem_wait);
    int cls;
    obs_q.delete();
    exp_q.delete();
    opcode = op;
    func_code = fn;
    cls = classify(op, fn);
    for (int i = 0; i <= int'(if_wait); i++) cycle(P_IF, cls, (i == int'(if_wait)));
    cycle(P_ID, cls, 1'($urandom));
    case (cls)
      C_ALU, C_IMM: begin cycle(P_EX, cls, 1'($urandom)); cycle(P_WB, cls, 1'($urandom)); end
      C_LWD, C_SWD: begin
        cycle(P_EX, cls, 1'($urandom));
        for (int i = 0; i <= int'(mem_wait); i++) cycle(P_MEM, cls, (i == int'(mem_wait)));
        if (cls == C_LWD) cycle(P_WB, cls, 1'($urandom));
      end
      C_BR:         cycle(P_EX, cls, 1'($urandom));
      C_JAL, C_JRL: cycle(P_WB, cls, 1'($urandom));
      default: ;
    endcase
    model_cnt++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (actual() !== expect_out(P_IF, C_ALU, 1'b0)) begin
      errors++; $display("FAIL reset_outputs got %h expected %h", actual(), expect_out(P_IF, C_ALU, 1'b0));
    end
    @(posedge clk); #1;
    checks++;
    if (actual() !== expect_out(P_IF, C_ALU, 1'b0) || num_inst !== 16'd0 || num_inst_s !== 4'd0) begin
      errors++; $display("FAIL reset_held got %h cnt %0d expected %h cnt 0", actual(), num_inst, expect_out(P_IF, C_ALU, 1'b0));
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_add();
    exec_instr(4'd15, 6'd0, 0, 0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL add cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (num_inst !== 16'(model_cnt)) begin errors++; $display("FAIL add_count got %0d expected %0d", num_inst, model_cnt); end
  endtask

  task automatic test_lwd();
    exec_instr(4'd7, 6'd0, 0, 3);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lwd cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (state !== 3'd0 || num_inst !== 16'(model_cnt)) begin
      errors++; $display("FAIL lwd_end got state %0d cnt %0d expected state 0 cnt %0d", state, num_inst, model_cnt);
    end
  endtask

  task automatic test_beq();
    exec_instr(4'd1, 6'd0, 0, 0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL beq cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (state !== 3'd0 || num_inst !== 16'(model_cnt)) begin
      errors++; $display("FAIL beq_end got state %0d cnt %0d expected state 0 cnt %0d", state, num_inst, model_cnt);
    end
  endtask

  task automatic test_jal_hlt();
    apply_reset();
    exec_instr(4'd10, 6'd0, 1, 0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL jal cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    exec_instr(4'd15, 6'd29, 0, 0);
    for (int i = 0; i < 10; i++) cycle(P_HALT, C_HLT, 1'($urandom));
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL hlt cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (num_inst !== 16'd2) begin errors++; $display("FAIL halt_count got %0d expected 2", num_inst); end
  endtask

  task automatic test_reset_mid_swd();
    apply_reset();
    exec_instr(4'd15, 6'd1, 0, 0);
    checks++;
    if (num_inst !== 16'd1) begin errors++; $display("FAIL pre_abort_count got %0d expected 1", num_inst); end
    obs_q.delete();
    exp_q.delete();
    opcode = 4'd8;
    func_code = 6'd0;
    cycle(P_IF, C_SWD, 1'b1);
    cycle(P_ID, C_SWD, 1'b0);
    cycle(P_EX, C_SWD, 1'b1);
    for (int i = 0; i < 3; i++) cycle(P_MEM, C_SWD, 1'b0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL swd_wait cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    mem_ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || num_inst !== 16'd0 || mem_write !== 1'b0 || mem_read !== 1'b1 || i_or_d !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got state %0d cnt %0d mw %b mr %b iod %b expected state 0 cnt 0 mw 0 mr 1 iod 0",
               state, num_inst, mem_write, mem_read, i_or_d);
    end
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    exec_instr(4'd15, 6'd28, 0, 0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_abort cycle %0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (num_inst !== 16'd1) begin errors++; $display("FAIL post_abort_count got %0d expected 1", num_inst); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int n = 0; n < 18; n++) begin
      exec_instr(4'd9, 6'd0, 0, 0);
      checks++;
      if (num_inst_s !== 4'(model_cnt) || num_inst !== 16'(model_cnt)) begin
        errors++; $display("FAIL wrap_count n %0d got %0d/%0d expected %0d", n, num_inst_s, num_inst, model_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [5:0] fn;
    int cls;
    logic [5:0] fn_tab [12];
    fn_tab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd25, 6'd26, 6'd28, 6'd40};
    apply_reset();
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 11));
      if (op == 4'd11) op = 4'd15;
      fn = fn_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 24) == 0) begin op = 4'd15; fn = 6'd29; end
      cls = classify(op, fn);
      exec_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      if (cls == C_HLT) for (int i = 0; i < 3; i++) cycle(P_HALT, C_HLT, 1'($urandom));
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand n %0d op %0d fn %0d cycle %0d got %h expected %h", n, op, fn, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (num_inst !== 16'(model_cnt) || num_inst_s !== 4'(model_cnt)) begin
        errors++; $display("FAIL rand_count n %0d got %0d/%0d expected %0d", n, num_inst, num_inst_s, model_cnt);
      end
      if (cls == C_HLT) apply_reset();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_lwd();
    test_beq();
    test_jal_hlt();
    test_reset_mid_swd();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcycle_control.md
MCYCLE_CONTROL -- requirements
Module: mcycle_control

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: width of num_inst.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port opcode, input, 4: instruction opcode from IR, `OPCODE_* encoding.
REQ-005 SHALL have port func_code, input, 6: R-type function field, `FUNC_* encoding.
REQ-006 SHALL have port bcond, input, 1: ALU branch-condition result (`OP_NE/EQ/GT).
REQ-007 SHALL have port mem_ready, input, 1: memory completes the current read/write this cycle.
REQ-008 SHALL have port state, output, 3: current FSM state (IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5).
REQ-009 SHALL have port alu_mode, output, 1: ALUMode to ALU control (0 = address add, 1 = opcode arithmetic).
REQ-010 SHALL have ports ir_write, pc_write, pc_write_cond, reg_write, output_valid, is_halted, each output, 1: datapath enables.
REQ-011 SHALL have ports mem_read, mem_write, i_or_d, each output, 1: memory request and address select (0 = PC, 1 = ALU result).
REQ-012 SHALL have port pc_src, output, 2: next-PC select (0 = PC+1, 1 = branch target, 2 = jump target, 3 = register rs).
REQ-013 SHALL have port num_inst, output, WORD_SIZE: retired-instruction count.

Function
REQ-014 SHALL implement a Moore FSM; every output except ir_write and pc_write SHALL depend only on state, opcode and func_code.
REQ-015 In IF, SHALL drive mem_read=1 and i_or_d=0, hold IF while mem_ready=0, and on mem_ready=1 pulse ir_write=1 and pc_write=1 with pc_src=0, then enter ID.
REQ-016 In ID, HLT SHALL enter HALT.
REQ-017 In ID, JMP SHALL drive pc_write=1 with pc_src=2; JPR SHALL drive pc_write=1 with pc_src=3; WWD SHALL drive output_valid=1; all three SHALL enter IF.
REQ-018 In ID, JAL and JRL SHALL drive pc_write=1 with pc_src=2 and 3 respectively, then enter WB.
REQ-019 In ID, all other opcodes SHALL enter EX; undefined func_code SHALL be treated as R-type ALU.
REQ-020 In EX, SHALL drive alu_mode=0 for LWD/SWD and enter MEM, and alu_mode=1 otherwise.
REQ-021 In EX, branches (BNE/BEQ/BGZ/BLZ) SHALL drive pc_write_cond=1 with pc_src=1, and enter IF.
REQ-022 In EX, R-type ALU, ADI, ORI and LHI SHALL enter WB.
REQ-023 In MEM, SHALL drive i_or_d=1 with mem_read=1 (LWD) or mem_write=1 (SWD), and hold until mem_ready=1; LWD SHALL then enter WB and SWD SHALL enter IF.
REQ-024 In WB, SHALL drive reg_write=1 for one cycle and enter IF.
REQ-025 HALT SHALL be absorbing until reset, with is_halted=1 and all other enables 0.
REQ-026 num_inst SHALL increment by 1 on every transition into IF or HALT from a non-IF state, wrapping modulo 2^WORD_SIZE.
REQ-027 mem_read and mem_write SHALL never be asserted together.
REQ-028 pc_write SHALL never be asserted while pc_write_cond=1.
REQ-029 mem_ready asserted outside IF/MEM SHALL be ignored.

Reset
REQ-030 reset=1 SHALL immediately force state=IF and num_inst=0, regardless of the clock.
REQ-031 While reset=1, all enables SHALL be 0 except the IF decodes mem_read=1 and i_or_d=0; ir_write and pc_write SHALL be held 0.
REQ-032 Reset asserted mid-instruction (any state, including a MEM wait) SHALL abort the instruction without incrementing num_inst.

Verification
REQ-033 ADD with mem_ready tied 1 -> state sequence IF,ID,EX,WB; reg_write high 1 cycle; num_inst 0->1 after 4 cycles.
REQ-034 LWD with mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_read=1 and i_or_d=1; then WB; total 8 cycles.
REQ-035 BEQ with bcond=1 -> EX drives pc_write_cond=1, pc_src=1, alu_mode=1; back in IF after 3 cycles.
REQ-036 JAL then HLT -> JAL: ID pc_src=2 then WB reg_write; HLT: is_halted=1 held 10 cycles; num_inst=2.
REQ-037 Async reset pulse mid-cycle during SWD MEM wait -> state=IF and num_inst=0 before next edge; mem_write=0.
REQ-038 num_inst preloaded at 16'hFFFF via a retiring instruction -> wraps to 0.
